utf8_stream_encoder: RTL

UTF8_STREAM_ENCODER -- requirements
Module: utf8_stream_encoder

---
 rtl/utf8_stream_encoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/utf8_stream_encoder.sv
// Streaming UTF-8 encoder: takes one Unicode scalar per handshake and emits its
// byte sequence as OUT_BYTES-wide beats. Invalid scalars are replaced with U+FFFD or dropped.
module utf8_stream_encoder #(
   parameter int OUT_BYTES = 1,
   parameter int REPLACE   = 1,
   parameter int CNT_W     = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [20:0]            in_codepoint,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*OUT_BYTES-1:0] out_data,
   output logic [2:0]             out_count,
   output logic                   out_last,
   output logic                   err,
   output logic [CNT_W-1:0]       char_count,
   output logic [CNT_W-1:0]       err_count
);

   typedef enum logic {IDLE, EMIT} state_t;

   typedef struct packed {
      logic [8*OUT_BYTES-1:0] data;
      logic [2:0]             cnt;
      logic                   last;
   } beat_t;

   state_t          state;
   logic [3:0][7:0] seq_buf;
   logic [2:0]      len;
   logic [2:0]      ptr;

   logic [3:0][7:0] enc_seq;
   logic [2:0]      enc_len;
   logic            enc_bad;
   logic            accept;
   logic            consume;
   beat_t           load_beat;
   beat_t           adv_beat;

   // Slice bytes p..min(p+OUT_BYTES,n)-1 of a sequence into lane order, lane 0 first.
   function automatic beat_t beat_of(input logic [3:0][7:0] seq, input logic [2:0] n,
                                     input logic [2:0] p);
      beat_t      b;
      logic [2:0] rem;
      logic [2:0] idx;
      b   = '0;
      rem = n - p;
      b.cnt = (rem > 3'(OUT_BYTES)) ? 3'(OUT_BYTES) : rem;
      for (int i = 0; i < OUT_BYTES; i++) begin
         idx = p + 3'(i);
         if (3'(i) < b.cnt) b.data[8*i +: 8] = seq[idx[1:0]];
      end
      b.last = ((p + b.cnt) == n);
      return b;
   endfunction

   always_comb begin
      enc_seq = '0;
      enc_len = 3'd0;
      enc_bad = 1'b0;
      if (in_codepoint > 21'h10FFFF ||
          (in_codepoint >= 21'h00D800 && in_codepoint <= 21'h00DFFF)) begin
         enc_bad = 1'b1;
         if (REPLACE != 0) begin
            enc_seq = {8'h00, 8'hBD, 8'hBF, 8'hEF};
            enc_len = 3'd3;
         end
      end else if (in_codepoint < 21'h80) begin
         enc_seq[0] = in_codepoint[7:0];
         enc_len    = 3'd1;
      end else if (in_codepoint < 21'h800) begin
         enc_seq[0] = {3'b110, in_codepoint[10:6]};
         enc_seq[1] = {2'b10, in_codepoint[5:0]};
         enc_len    = 3'd2;
      end else if (in_codepoint < 21'h10000) begin
         enc_seq[0] = {4'b1110, in_codepoint[15:12]};
         enc_seq[1] = {2'b10, in_codepoint[11:6]};
         enc_seq[2] = {2'b10, in_codepoint[5:0]};
         enc_len    = 3'd3;
      end else begin
         enc_seq[0] = {5'b11110, in_codepoint[20:18]};
         enc_seq[1] = {2'b10, in_codepoint[17:12]};
         enc_seq[2] = {2'b10, in_codepoint[11:6]};
         enc_seq[3] = {2'b10, in_codepoint[5:0]};
         enc_len    = 3'd4;
      end
   end

   assign out_valid = (state == EMIT);
   assign consume   = out_valid & out_ready;
   // A new character may enter in the same cycle the last beat of the previous one leaves.
   assign in_ready  = ~reset & ((state == IDLE) | (consume & out_last));
   assign accept    = in_valid & in_ready;
   assign load_beat = beat_of(enc_seq, enc_len, 3'd0);
   assign adv_beat  = beat_of(seq_buf, len, ptr + out_count);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         seq_buf    <= '0;
         len        <= 3'd0;
         ptr        <= 3'd0;
         out_data   <= '0;
         out_count  <= 3'd0;
         out_last   <= 1'b0;
         err        <= 1'b0;
         char_count <= '0;
         err_count  <= '0;
      end else begin
         err <= accept & enc_bad;
         if (accept && char_count != {CNT_W{1'b1}}) char_count <= char_count + 1'b1;
         if (accept && enc_bad && err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;

         if (accept && enc_len != 3'd0) begin
            state     <= EMIT;
            seq_buf   <= enc_seq;
            len       <= enc_len;
            ptr       <= 3'd0;
            out_data  <= load_beat.data;
            out_count <= load_beat.cnt;
            out_last  <= load_beat.last;
         end else if (consume) begin
            if (out_last) begin
               state     <= IDLE;
               len       <= 3'd0;
               ptr       <= 3'd0;
               out_data  <= '0;
               out_count <= 3'd0;
               out_last  <= 1'b0;
            end else begin
               ptr       <= ptr + out_count;
               out_data  <= adv_beat.data;
               out_count <= adv_beat.cnt;
               out_last  <= adv_beat.last;
            end
         end
      end
   end

endmodule
